// File: rtl/lacc_pkg.sv
// Shared encodings and helpers for the lacc_data request channel.
package lacc_pkg;
    localparam int unsigned LACC_DW = 32;

    typedef enum logic [1:0] {
        LACC_SIZE_BYTE = 2'd0,
        LACC_SIZE_HALF = 2'd1,
        LACC_SIZE_WORD = 2'd2,
        LACC_SIZE_BAD  = 2'd3
    } lacc_size_e;

    // Byte-lane write strobe for an aligned access; illegal size yields no lanes.
    function automatic logic [3:0] lacc_strobe(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] s;
        s = '0;
        case (size)
            LACC_SIZE_BYTE: s = 4'b0001 << lane;
            LACC_SIZE_HALF: s = lane[1] ? 4'b1100 : 4'b0011;
            LACC_SIZE_WORD: s = '1;
            default:        s = '0;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/lacc_mem_responder_if.sv
// lacc_data command channel plus its fixed-latency read response.
interface lacc_mem_responder_if;
    import lacc_pkg::*;

    logic               lacc_data_valid;
    logic               lacc_data_ready;
    logic [31:0]        lacc_data_addr;
    logic               lacc_data_read;
    logic [LACC_DW-1:0] lacc_data_wdata;
    logic [1:0]         lacc_data_size;
    logic               lacc_drsp_valid;
    logic [LACC_DW-1:0] lacc_drsp_rdata;

    modport master (
        output lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
        input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata
    );

    modport slave (
        input  lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
        output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata
    );
endinterface

// File: rtl/lacc_sram.sv
// Single-port word SRAM with byte write enables and a registered read port.
module lacc_sram
    import lacc_pkg::*;
#(
    parameter  int unsigned DEPTH = 4096,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic [3:0]         we,
    input  logic [AW-1:0]      addr,
    input  logic [LACC_DW-1:0] wdata,
    output logic [LACC_DW-1:0] rdata
);
    logic [LACC_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            if (we == '0) rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/lacc_mem_responder.sv
// Memory-side responder: decodes lacc commands onto a shared SRAM, 1-cycle read response.
module lacc_mem_responder
    import lacc_pkg::*;
#(
    parameter  int unsigned DEPTH     = 4096,
    parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    lacc_mem_responder_if.slave lacc,
    input  logic               host_en,
    input  logic               host_we,
    input  logic [AW-1:0]      host_addr,
    input  logic [LACC_DW-1:0] host_wdata,
    output logic [LACC_DW-1:0] host_rdata,
    input  logic               stall_i,
    input  logic               stat_clr,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count,
    output logic               err
);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic               ready, hsk, oor, mis, bad, rsp_live;
    logic [31:0]        off;
    logic [AW-1:0]      idx;
    logic               sram_en;
    logic [3:0]         sram_we;
    logic [AW-1:0]      sram_addr;
    logic [LACC_DW-1:0] sram_wdata, sram_q;
    logic               rsp_valid, rsp_bad, host_pend;
    logic [LACC_DW-1:0] lacc_q, host_q;

    always_comb begin
        off   = lacc.lacc_data_addr - BASE_ADDR;
        idx   = off[2 +: AW];
        oor   = off >= SPAN;
        mis   = 1'b0;
        case (lacc.lacc_data_size)
            LACC_SIZE_BYTE: mis = 1'b0;
            LACC_SIZE_HALF: mis = lacc.lacc_data_addr[0];
            LACC_SIZE_WORD: mis = |lacc.lacc_data_addr[1:0];
            default:        mis = 1'b1;
        endcase
        bad   = oor | mis;
        ready = ~rst & ~host_en & ~stall_i;
        hsk   = lacc.lacc_data_valid & ready;

        // Host owns the port whenever enabled; ready is low then, so no lacc access collides.
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = idx;
        sram_wdata = lacc.lacc_data_wdata;
        if (host_en) begin
            sram_en    = 1'b1;
            sram_we    = host_we ? 4'b1111 : 4'b0000;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end else if (hsk && !bad) begin
            sram_en = 1'b1;
            sram_we = lacc.lacc_data_read ? 4'b0000
                                          : lacc_strobe(lacc.lacc_data_size, lacc.lacc_data_addr[1:0]);
        end
    end

    lacc_sram #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_q)
    );

    // The SRAM output is only meaningful right after a read; the *_q registers hold it afterwards.
    // rst gates the pending response immediately so it dies in the reset cycle itself.
    assign rsp_live             = rsp_valid & ~rst;
    assign lacc.lacc_data_ready = ready;
    assign lacc.lacc_drsp_valid = rsp_live;
    assign lacc.lacc_drsp_rdata = rsp_live ? (rsp_bad ? '0 : sram_q) : lacc_q;
    assign host_rdata           = host_pend ? sram_q : host_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_bad   <= 1'b0;
            host_pend <= 1'b0;
            lacc_q    <= '0;
            host_q    <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= hsk & lacc.lacc_data_read;
            rsp_bad   <= bad;
            host_pend <= host_en & ~host_we;
            lacc_q    <= lacc.lacc_drsp_rdata;
            host_q    <= host_rdata;
            if (stat_clr) begin
                rd_count <= '0;
                wr_count <= '0;
                err      <= 1'b0;
            end else if (hsk) begin
                if (lacc.lacc_data_read) rd_count <= rd_count + 32'd1;
                else                     wr_count <= wr_count + 32'd1;
                if (bad) err <= 1'b1;
            end
        end
    end
endmodule
